dft_bin_streamer: RTL

DFT_BIN_STREAMER -- requirements
Module: dft_bin_streamer

---
 rtl/dft_bin_streamer_pkg.sv | 10 +
 rtl/dft_bin_streamer_cplx_abs_sum.sv | 16 +
 rtl/dft_bin_streamer.sv | 86 ++++++++
 3 files changed

// File: rtl/dft_bin_streamer_pkg.sv
// dft_bin_streamer_pkg: shared DFT defaults, FSM state encoding and index-width helper
package dft_bin_streamer_pkg;
    localparam int N_DEF   = 16;
    localparam int NPT_DEF = 32;
    function automatic int idx_w(input int npt);
        return $clog2(npt);
    endfunction
    localparam int IDX_W = idx_w(NPT_DEF);
    typedef enum logic {IDLE, STREAM} state_t;
endpackage

// File: rtl/dft_bin_streamer_cplx_abs_sum.sv
// cplx_abs_sum: y = |a| + |b| for two's-complement a, b, widened to N+1 bits so nothing overflows
//   a, b : N-bit signed components
//   y    : N+1-bit unsigned magnitude sum
module cplx_abs_sum #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N:0]   y
);
    logic [N:0] ea, eb;
    assign ea = {a[N-1], a};
    assign eb = {b[N-1], b};
    // negating in N+1 bits keeps |-2^(N-1)| exact
    assign y  = (a[N-1] ? -ea : ea) + (b[N-1] ? -eb : eb);
endmodule

// File: rtl/dft_bin_streamer.sv
// dft_bin_streamer: captures a full DFT frame and streams its bins out one per handshake
//   clk2, rst          : clock, asynchronous active-low reset
//   frame_valid/ready  : frame strobe in, bins_r/bins_i packed NPT x N-bit components
//   out_valid/ready    : output beat handshake carrying out_r, out_i, out_mag, out_idx, out_last
//   drop_cnt           : saturating count of frames offered while busy
module dft_bin_streamer
    import dft_bin_streamer_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int Q   = 0,
    parameter int NPT = NPT_DEF
) (
    input  logic                    clk2,
    input  logic                    rst,
    input  logic                    frame_valid,
    input  logic [NPT*N-1:0]        bins_r,
    input  logic [NPT*N-1:0]        bins_i,
    output logic                    frame_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N-1:0]            out_r,
    output logic [N-1:0]            out_i,
    output logic [N:0]              out_mag,
    output logic [idx_w(NPT)-1:0]   out_idx,
    output logic                    out_last,
    output logic [7:0]              drop_cnt
);
    localparam int IW = idx_w(NPT);
    localparam logic [IW-1:0] LAST = IW'(NPT - 1);
    // Q only describes the fixed-point format; the data path passes it through untouched
    if (Q < 0 || Q >= N) begin : g_q_out_of_range
        $error("dft_bin_streamer: Q must lie in [0, N)");
    end
    state_t          state;
    logic [NPT*N-1:0] buf_r, buf_i;
    logic            xfer, cap, load;
    logic [IW-1:0]   nxt_idx;
    logic [N-1:0]    nxt_r, nxt_i;
    logic [N:0]      nxt_mag;
    assign xfer        = out_valid & out_ready;
    assign frame_ready = (state == IDLE) | (xfer & out_last);
    assign cap         = frame_valid & frame_ready;
    assign load        = cap | (xfer & ~out_last);
    assign nxt_idx     = cap ? '0 : out_idx + IW'(1);
    // bin 0 of a fresh capture comes straight from the inputs, since the buffer fills on the same edge
    assign nxt_r       = cap ? bins_r[N-1:0] : buf_r[nxt_idx*N +: N];
    assign nxt_i       = cap ? bins_i[N-1:0] : buf_i[nxt_idx*N +: N];
    cplx_abs_sum #(.N(N)) u_abs (
        .a (nxt_r),
        .b (nxt_i),
        .y (nxt_mag)
    );
    always_ff @(posedge clk2) begin
        if (cap) begin
            buf_r <= bins_r;
            buf_i <= bins_i;
        end
    end
    always_ff @(posedge clk2 or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_r     <= '0;
            out_i     <= '0;
            out_mag   <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (frame_valid && !frame_ready && drop_cnt != 8'hff)
                drop_cnt <= drop_cnt + 8'd1;
            if (load) begin
                state     <= STREAM;
                out_valid <= 1'b1;
                out_r     <= nxt_r;
                out_i     <= nxt_i;
                out_mag   <= nxt_mag;
                out_idx   <= nxt_idx;
                out_last  <= nxt_idx == LAST;
            end else if (xfer) begin
                state     <= IDLE;
                out_valid <= 1'b0;
            end
        end
    end
endmodule
